float_div_issuer: RTL and testbench

Request-side front end for the pipelined floating-point divider in the CNN datapath. Accepts dividend/divisor pairs on a valid/ready stream and drives the divider's `enb`/`A`/`B` inputs. Captures each `C` on `ack` into an in-order result buffer and presents results on a second valid/ready stream. Credit-based issue guarantees no result is ever dropped when the consumer stalls.

---
 rtl/float_div_issuer.sv | 169 ++++++++++++++++
 tb/tb_float_div_issuer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_div_issuer.sv
`default_nettype none
// ============================================================================
// Module   : float_div_issuer
// Brief    : Credit-based request front end and in-order result buffer for a
//            fixed-latency pipelined floating-point divider. Optional zero
//            operand bypass is enabled by defining FLOAT_DIV_SPECIAL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module float_div_issuer #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 5,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  div_enb,
    output logic [DATA_WIDTH-1:0] div_a,
    output logic [DATA_WIDTH-1:0] div_b,
    input  logic                  div_ack,
    input  logic [DATA_WIDTH-1:0] div_c,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  err
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W:0] c_DEPTH_CNT = (c_CNT_W + 1)'(DEPTH);

    if (LATENCY < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("float_div_issuer: LATENCY must be >= 1 and DEPTH a power of two >= 2");
    end

    logic [c_CNT_W-1:0]    r_inflight;
    logic [c_CNT_W-1:0]    r_fcount;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_div_enb;
    logic [DATA_WIDTH-1:0] r_div_a;
    logic [DATA_WIDTH-1:0] r_div_b;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_complete;
    logic                  w_spurious;
    logic                  w_pop;
    logic [c_CNT_W:0]      w_used;
    logic [DATA_WIDTH-1:0] w_issue_a;
    logic [DATA_WIDTH-1:0] w_issue_b;
    logic [DATA_WIDTH-1:0] w_result;

    // Results still in the divider already own a buffer slot, so the
    // buffer can never overflow however long the consumer stalls.
    assign w_used     = {1'b0, r_inflight} + {1'b0, r_fcount};
    assign in_ready   = !rst && (w_used < c_DEPTH_CNT);
    assign w_accept   = in_valid && in_ready;
    assign w_complete = div_ack && (r_inflight != '0);
    assign w_spurious = div_ack && (r_inflight == '0);
    assign out_valid  = (r_fcount != '0);
    assign w_pop      = out_valid && out_ready;
    assign out_data   = r_mem[r_rd_ptr];

    assign div_enb = r_div_enb;
    assign div_a   = r_div_a;
    assign div_b   = r_div_b;
    assign err     = r_err;

`ifdef FLOAT_DIV_SPECIAL_EN
    localparam int c_MANT_W = (DATA_WIDTH == 16) ? 10 : ((DATA_WIDTH == 64) ? 52 : 23);
    localparam logic [DATA_WIDTH-2:0] c_INF_MAG =
        {{(DATA_WIDTH - 1 - c_MANT_W){1'b1}}, {c_MANT_W{1'b0}}};

    logic                  w_a_zero;
    logic                  w_b_zero;
    logic                  w_sign;
    logic                  w_bypass;
    logic [DATA_WIDTH-1:0] w_subst;
    logic [LATENCY:0]      r_byp;
    logic [DATA_WIDTH-1:0] r_sub [LATENCY + 1];

    assign w_a_zero  = (in_a[DATA_WIDTH-2:0] == '0);
    assign w_b_zero  = (in_b[DATA_WIDTH-2:0] == '0);
    assign w_sign    = in_a[DATA_WIDTH-1] ^ in_b[DATA_WIDTH-1];
    assign w_bypass  = w_a_zero || w_b_zero;
    // A zero divisor dominates: 0/0 also yields the signed infinity.
    assign w_subst   = w_b_zero ? {w_sign, c_INF_MAG} : {w_sign, {(DATA_WIDTH - 1){1'b0}}};
    assign w_issue_a = w_bypass ? '0 : in_a;
    assign w_issue_b = w_bypass ? '0 : in_b;
    // Stage LATENCY lines up with the ack of the request captured LATENCY+1 edges ago.
    assign w_result  = r_byp[LATENCY] ? r_sub[LATENCY] : div_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byp <= '0;
        end else begin
            r_byp <= {r_byp[LATENCY-1:0], w_accept && w_bypass};
        end
        r_sub[0] <= w_subst;
        for (int i = 1; i <= LATENCY; i++) begin
            r_sub[i] <= r_sub[i-1];
        end
    end
`else
    assign w_issue_a = in_a;
    assign w_issue_b = in_b;
    assign w_result  = div_c;
`endif

    // The divider expects zeros on A/B whenever enb is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_enb <= 1'b0;
            r_div_a   <= '0;
            r_div_b   <= '0;
        end else if (w_accept) begin
            r_div_enb <= 1'b1;
            r_div_a   <= w_issue_a;
            r_div_b   <= w_issue_b;
        end else begin
            r_div_enb <= 1'b0;
            r_div_a   <= '0;
            r_div_b   <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
            r_fcount   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_err      <= 1'b0;
        end else begin
            case ({w_accept, w_complete})
                2'b10:   r_inflight <= r_inflight + c_CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - c_CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
            case ({w_complete, w_pop})
                2'b10:   r_fcount <= r_fcount + c_CNT_W'(1);
                2'b01:   r_fcount <= r_fcount - c_CNT_W'(1);
                default: r_fcount <= r_fcount;
            endcase
            if (w_complete) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_complete) begin
            r_mem[r_wr_ptr] <= w_result;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_float_div_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_float_div_issuer
// Brief    : Directed bench for float_div_issuer with an exponent-subtract
//            model divider (exact for equal-mantissa positive operands).
// Revision : 1.0 - initial release
// ============================================================================
module tb_float_div_issuer;

    localparam int DW  = 32;
    localparam int LAT = 5;
    localparam int DEP = 8;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          div_enb;
    logic [DW-1:0] div_a;
    logic [DW-1:0] div_b;
    logic          div_ack;
    logic [DW-1:0] div_c;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          err;

    always #5 clk = ~clk;

    float_div_issuer #(.DATA_WIDTH(DW), .LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .div_enb(div_enb), .div_a(div_a), .div_b(div_b),
        .div_ack(div_ack), .div_c(div_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err(err)
    );

    // Model divider: never reset, so requests in flight across a reset turn into stray acks.
    logic [LAT-1:0] m_v = '0;
    logic [DW-1:0]  m_a [LAT];
    logic [DW-1:0]  m_b [LAT];

    always @(posedge clk) begin
        m_v    <= {m_v[LAT-2:0], div_enb};
        m_a[0] <= div_a;
        m_b[0] <= div_b;
        for (int i = 1; i < LAT; i++) begin
            m_a[i] <= m_a[i-1];
            m_b[i] <= m_b[i-1];
        end
    end
    assign div_ack = m_v[LAT-1];
    assign div_c   = div_ack ? (m_a[LAT-1] - m_b[LAT-1] + 32'h3F800000) : 32'h0BAD0BAD;

    vec_t          vecs [20];
    vec_t          src_q [$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];
    int            n_chk = 0;
    int            n_err = 0;
    int            n_acc = 0;
    int            n_stall = 0;
    logic          s_ir, s_enb, s_ov, s_err;
    logic [DW-1:0] s_a, s_b, s_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // One clock: sample at the falling edge, drive just after the rising edge.
    task automatic step();
        vec_t tmp;
        @(negedge clk);
        s_ir   = in_ready;
        s_enb  = div_enb;
        s_a    = div_a;
        s_b    = div_b;
        s_ov   = out_valid;
        s_data = out_data;
        s_err  = err;
        if (in_valid && in_ready) begin
            tmp = src_q.pop_front();
            exp_q.push_back(tmp.c);
            n_acc++;
        end
        if (in_valid && !in_ready) n_stall++;
        if (out_valid && out_ready) got_q.push_back(out_data);
        @(posedge clk);
        #1;
        if (src_q.size() > 0) begin
            in_valid = 1'b1;
            in_a     = src_q[0].a;
            in_b     = src_q[0].b;
        end else begin
            in_valid = 1'b0;
            in_a     = 32'hDEADBEEF;
            in_b     = 32'h12345678;
        end
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (src_q.size() == 0 && !in_valid && got_q.size() == exp_q.size()) break;
            step();
        end
    endtask

    task automatic compare_queues(input string name);
        check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_res%0d", name, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int k;
        // Equal-mantissa operand pairs; quotients worked out by hand.
        vecs[0]  = '{32'h40C00000, 32'h40400000, 32'h40000000}; // 6/3
        vecs[1]  = '{32'h41000000, 32'h40000000, 32'h40800000}; // 8/2
        vecs[2]  = '{32'h3F800000, 32'h40800000, 32'h3E800000}; // 1/4
        vecs[3]  = '{32'h41400000, 32'h3FC00000, 32'h41000000}; // 12/1.5
        vecs[4]  = '{32'h40A00000, 32'h41200000, 32'h3F000000}; // 5/10
        vecs[5]  = '{32'h42000000, 32'h3F800000, 32'h42000000}; // 32/1
        vecs[6]  = '{32'h3F400000, 32'h41400000, 32'h3D800000}; // 0.75/12
        vecs[7]  = '{32'h41A00000, 32'h40200000, 32'h41000000}; // 20/2.5
        vecs[8]  = '{32'h42800000, 32'h40000000, 32'h42000000}; // 64/2
        vecs[9]  = '{32'h3E000000, 32'h3E000000, 32'h3F800000}; // 0.125/0.125
        vecs[10] = '{32'h41C00000, 32'h40C00000, 32'h40800000}; // 24/6
        vecs[11] = '{32'h42400000, 32'h3F400000, 32'h42800000}; // 48/0.75
        vecs[12] = '{32'h40000000, 32'h41800000, 32'h3E000000}; // 2/16
        vecs[13] = '{32'h40400000, 32'h40C00000, 32'h3F000000}; // 3/6
        vecs[14] = '{32'h41800000, 32'h3E800000, 32'h42800000}; // 16/0.25
        vecs[15] = '{32'h40200000, 32'h40A00000, 32'h3F000000}; // 2.5/5
        vecs[16] = '{32'h3FC00000, 32'h42400000, 32'h3D000000}; // 1.5/48
        vecs[17] = '{32'h41200000, 32'h40200000, 32'h40800000}; // 10/2.5
        vecs[18] = '{32'h40800000, 32'h3F000000, 32'h41000000}; // 4/0.5
        vecs[19] = '{32'h42000000, 32'h42800000, 32'h3F000000}; // 32/64

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 32'hDEADBEEF;
        in_b      = 32'h12345678;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        step();
        step();
        check("rst_in_ready", 32'(s_ir), 0);
        check("rst_div_enb", 32'(s_enb), 0);
        check("rst_div_a", s_a, 0);
        check("rst_div_b", s_b, 0);
        check("rst_out_valid", 32'(s_ov), 0);
        check("rst_err", 32'(s_err), 0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", 32'(s_ir), 1);

        // Single request: latency and idle zeros.
        out_ready = 1'b1;
        src_q.push_back(vecs[0]);
        acc0 = n_acc;
        for (int i = 0; i < 5 && n_acc == acc0; i++) step();
        check("single_accept", 32'(n_acc - acc0), 1);
        step();
        check("single_enb", 32'(s_enb), 1);
        check("single_div_a", s_a, 32'h40C00000);
        check("single_div_b", s_b, 32'h40400000);
        k = 1;
        while (!s_ov && k < 20) begin
            step();
            k++;
        end
        check("single_latency", 32'(k), 7);
        check("single_data", s_data, 32'h40000000);
        step();
        check("idle_enb", 32'(s_enb), 0);
        check("idle_div_a", s_a, 0);
        check("idle_div_b", s_b, 0);
        compare_queues("single");

        // Back-to-back burst with a free-running consumer.
        for (int i = 0; i < 20; i++) src_q.push_back(vecs[i]);
        acc0 = n_acc;
        n_stall = 0;
        drain(80);
        check("burst_accepts", 32'(n_acc - acc0), 20);
        check("burst_stalls", 32'(n_stall), 0);
        compare_queues("burst");

        // Consumer stalled: credit runs out at exactly DEPTH requests.
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) src_q.push_back(vecs[i]);
        acc0 = n_acc;
        for (int i = 0; i < 30; i++) step();
        check("bp_accepts", 32'(n_acc - acc0), DEP);
        check("bp_in_ready", 32'(s_ir), 0);
        check("bp_out_valid", 32'(s_ov), 1);
        check("bp_no_pop", 32'(got_q.size()), 0);
        out_ready = 1'b1;
        drain(100);
        check("bp_total_accepts", 32'(n_acc - acc0), 12);
        compare_queues("bp");

        // Nearly full buffer, then concurrent issue/ack and push/pop with wrap.
        out_ready = 1'b0;
        for (int i = 12; i < 19; i++) src_q.push_back(vecs[i]);
        for (int i = 0; i < 20; i++) step();
        check("near_full_in_ready", 32'(s_ir), 1);
        check("near_full_out_valid", 32'(s_ov), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) src_q.push_back(vecs[(i + 5) % 20]);
        drain(100);
        compare_queues("wrap");

        // Reset with three requests in flight.
        for (int i = 0; i < 3; i++) src_q.push_back(vecs[i + 4]);
        acc0 = n_acc;
        for (int i = 0; i < 10 && (n_acc - acc0) < 3; i++) step();
        check("mid_accepts", 32'(n_acc - acc0), 3);
        rst = 1'b1;
        step();
        check("mid_rst_in_ready", 32'(s_ir), 0);
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        step();
        check("mid_rst_enb", 32'(s_enb), 0);
        check("mid_rst_div_a", s_a, 0);
        check("mid_rst_out_valid", 32'(s_ov), 0);
        check("mid_rst_err", 32'(s_err), 0);
        check("mid_rst_in_ready_after", 32'(s_ir), 1);
        for (int i = 0; i < 10; i++) step();
        check("stray_err", 32'(s_err), 1);
        check("stray_out_valid", 32'(s_ov), 0);
        check("stray_no_result", 32'(got_q.size()), 0);
        src_q.push_back(vecs[9]);
        drain(40);
        check("err_sticky", 32'(s_err), 1);
        compare_queues("post_rst");

`ifdef FLOAT_DIV_SPECIAL_EN
        src_q.push_back(vecs[1]);
        src_q.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000}); // 1/0
        src_q.push_back(vecs[0]);
        src_q.push_back('{32'h80000000, 32'h40000000, 32'h80000000}); // -0/2
        src_q.push_back('{32'h3F800000, 32'h80000000, 32'hFF800000}); // 1/-0
        src_q.push_back(vecs[3]);
        drain(60);
        compare_queues("special");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
